// File: rtl/mbox_pkg.sv
// Shared types and constants for the KL10 memory-box controller.
package mbox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_PAUSE,
    ST_WRITEBACK
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_RD,
    OP_WR,
    OP_RPW
  } op_e;

  typedef logic [10:0] pf_disp_t;

  localparam pf_disp_t PF_NXM   = 11'o1000;
  localparam int       AC_WORDS = 16;

  // Exactly one of read/write selects an op; anything else is not a request.
  function automatic op_e decode_op(input logic rd, input logic wr, input logic pse);
    if (rd && !wr) return pse ? OP_RPW : OP_RD;
    if (wr && !rd) return OP_WR;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/mbox_if.sv
// EBOX <-> memory-box request/response bundle.
interface mbox_if
  import mbox_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 36
) ();

  logic [ADDR_W-1:0] vma;
  logic              vmaACRef;
  logic [DATA_W-1:0] writeData;
  logic              req;
  logic              read;
  logic              write;
  logic              PSE;
  logic [DATA_W-1:0] cacheData;
  pf_disp_t          pfDisp;
  logic              memAck;
  logic              busy;

  modport master (
    output vma, vmaACRef, writeData, req, read, write, PSE,
    input  cacheData, pfDisp, memAck, busy
  );

  modport slave (
    input  vma, vmaACRef, writeData, req, read, write, PSE,
    output cacheData, pfDisp, memAck, busy
  );

endinterface

// File: rtl/mbox_ram.sv
// Single-port synchronous word RAM; read data updates only on a read cycle.
module mbox_ram #(
  parameter int DATA_W    = 36,
  parameter int DEPTH     = 4096,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage arrays carry no reset so they map onto RAM macros; contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mbox_ctl.sv
// Memory-box controller: wait-state sequencing, fast-AC file, NXM page fail
// and read-pause-write interlock in front of mbox_ram.
module mbox_ctl
  import mbox_pkg::*;
#(
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 36,
  parameter int DEPTH   = 4096,
  parameter int MEM_LAT = 2
) (
  input logic   clk,
  input logic   reset,
  mbox_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  localparam logic [1:0] IDLE      = ST_IDLE;
  localparam logic [1:0] ACCESS    = ST_ACCESS;
  localparam logic [1:0] PAUSE     = ST_PAUSE;
  localparam logic [1:0] WRITEBACK = ST_WRITEBACK;

  logic [1:0]        state;
  op_e               op_q;
  logic              ac_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] data_q;
  logic              ram_sel;
  logic              ack_q;
  logic              busy_q;
  pf_disp_t          pf_q;

  logic [DATA_W-1:0] ac_file [AC_WORDS];
  logic [DATA_W-1:0] ram_rdata;

  op_e  req_op;
  logic idle_go;
  logic pause_go;
  logic req_nxm;
  logic ram_issue;
  logic ac_we;

  assign req_op    = decode_op(bus.read, bus.write, bus.PSE);
  assign idle_go   = (state == IDLE) && bus.req && (req_op != OP_NONE);
  assign pause_go  = (state == PAUSE) && bus.req && (req_op == OP_WR);
  assign req_nxm   = !bus.vmaACRef && ({1'b0, bus.vma} >= (ADDR_W + 1)'(DEPTH));
  assign ram_issue = ((state == ACCESS) || (state == WRITEBACK)) && (cnt == '0);
  assign ac_we     = !reset && ((idle_go && bus.vmaACRef && (req_op == OP_WR)) ||
                                (pause_go && ac_q));

  // A paused write reuses the AC index latched by the read.
  always_ff @(posedge clk) begin
    if (ac_we) ac_file[pause_go ? addr_q[3:0] : bus.vma[3:0]] <= bus.writeData;
  end

  mbox_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .en    (ram_issue),
    .we    (op_q == OP_WR),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= OP_NONE;
      ac_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      data_q  <= '0;
      ram_sel <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      pf_q    <= '0;
    end else begin
      ack_q   <= 1'b0;
      ram_sel <= 1'b0;
      if (ram_sel) data_q <= ram_rdata;
      case (state)
        IDLE: if (idle_go) begin
          op_q    <= req_op;
          ac_q    <= bus.vmaACRef;
          addr_q  <= bus.vma[AW-1:0];
          wdata_q <= bus.writeData;
          pf_q    <= '0;
          if (bus.vmaACRef) begin
            ack_q <= 1'b1;
            if (req_op != OP_WR) data_q <= ac_file[bus.vma[3:0]];
            if (req_op == OP_RPW) begin
              state  <= PAUSE;
              busy_q <= 1'b1;
            end
          end else if (req_nxm) begin
            ack_q <= 1'b1;
            pf_q  <= PF_NXM;
          end else begin
            state  <= ACCESS;
            cnt    <= CNT_LOAD;
            busy_q <= 1'b1;
          end
        end
        ACCESS, WRITEBACK: begin
          if (cnt == '0) begin
            ack_q <= 1'b1;
            if (op_q != OP_WR) ram_sel <= 1'b1;
            if (op_q == OP_RPW) begin
              state <= PAUSE;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PAUSE: if (pause_go) begin
          op_q    <= OP_WR;
          wdata_q <= bus.writeData;
          pf_q    <= '0;
          if (ac_q) begin
            ack_q  <= 1'b1;
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            state <= WRITEBACK;
            cnt   <= CNT_LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM read data is itself a register; it is forwarded during the ack cycle, then held in data_q.
  assign bus.cacheData = ram_sel ? ram_rdata : data_q;
  assign bus.pfDisp    = pf_q;
  assign bus.memAck    = ack_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mbox_ctl.sv
// Self-checking bench for mbox_ctl: transaction-level reference model plus directed checks.
module tb_mbox_ctl;
  import mbox_pkg::*;

  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 36;
  localparam int DEPTH   = 4096;
  localparam int MEM_LAT = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mbox_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mbox_ctl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MEM_LAT(MEM_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: requester-visible behaviour as transactions with completion times.
  localparam int M_FREE = 0, M_WAIT = 1, M_PAUSED = 2;
  int                mode      = M_FREE;
  longint            k         = 0;
  longint            done_edge = 0;
  logic              m_ac, m_wr, m_rpw;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_acc     = 1'b0;
  logic              exp_ack   = 1'b0;
  logic              exp_busy  = 1'b0;
  logic [10:0]       exp_pf    = '0;
  logic [DATA_W-1:0] exp_cache = '0;
  logic [DATA_W-1:0] mem_m [int];
  logic [DATA_W-1:0] acm [16];

  task automatic complete();
    if (m_ac) begin
      if (m_wr) acm[m_addr[3:0]] = m_wdata;
      else      exp_cache = acm[m_addr[3:0]];
    end else if (m_wr) begin
      mem_m[int'(m_addr)] = m_wdata;
    end else begin
      exp_cache = mem_m[int'(m_addr)];
    end
    exp_ack = 1'b1;
    mode    = m_rpw ? M_PAUSED : M_FREE;
  endtask

  task automatic start();
    if (m_ac) complete();
    else if (m_addr >= DEPTH) begin
      exp_pf  = PF_NXM;
      exp_ack = 1'b1;
      mode    = M_FREE;
    end else begin
      mode      = M_WAIT;
      done_edge = k + MEM_LAT;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mode = M_FREE; exp_ack = 0; exp_busy = 0; exp_pf = '0; exp_cache = '0; m_acc = 0;
    end else begin
      k++;
      exp_ack = 1'b0;
      m_acc   = 1'b0;
      if (mode == M_WAIT) begin
        if (k == done_edge) complete();
      end else if (bus.req && (bus.read != bus.write)) begin
        if (mode == M_FREE) begin
          m_acc = 1; m_ac = bus.vmaACRef; m_addr = bus.vma; m_wr = bus.write;
          m_rpw = bus.read && bus.PSE; m_wdata = bus.writeData; exp_pf = '0;
          start();
        end else if (bus.write) begin
          m_acc = 1; m_wr = 1; m_rpw = 0; m_wdata = bus.writeData; exp_pf = '0;
          start();
        end
      end
      exp_busy = (mode != M_FREE);
    end
  end

  bit cmp_on = 1'b0;
  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      check("memAck", bus.memAck, exp_ack);
      check("busy", bus.busy, exp_busy);
      check("pfDisp", bus.pfDisp, exp_pf);
      check("cacheData", bus.cacheData, exp_cache);
    end
  end

  task automatic idle_inputs();
    bus.req = 0; bus.read = 0; bus.write = 0; bus.PSE = 0;
    bus.vmaACRef = 0; bus.vma = '0; bus.writeData = '0;
  endtask

  task automatic drive(input bit rd, input bit wr, input bit pse, input bit ac,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req = 1; bus.read = rd; bus.write = wr; bus.PSE = pse;
    bus.vmaACRef = ac; bus.vma = a; bus.writeData = d;
  endtask

  task automatic wait_accept(output bit got);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (m_acc) got = 1;
    end
    idle_inputs();
    check("op_accept", got, 1);
  endtask

  // Issues one op, returns the number of cycles from acceptance to memAck (-1 on timeout).
  task automatic run_op(input bit rd, input bit wr, input bit pse, input bit ac,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, output int lat);
    bit got;
    lat = -1;
    drive(rd, wr, pse, ac, a, d);
    wait_accept(got);
    if (got) begin
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (bus.memAck) begin
          lat = i;
          break;
        end
      end
    end
  endtask

  task automatic count_acks(input int cycles, output int acks);
    acks = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.memAck) acks++;
    end
  endtask

  int                pool [8] = '{0, 5, 100, 200, 300, 4095, 1234, 77};
  logic [DATA_W-1:0] init_val [8];
  localparam logic [DATA_W-1:0] WORD_900 = 36'h5A5A_1234_5;
  localparam logic [DATA_W-1:0] WORD_960 = 36'o707070707070;

  initial begin
    int lat, acks, gap, r;
    bit got;
    idle_inputs();
    #23 reset = 1'b0;
    cmp_on = 1'b1;
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_memAck", bus.memAck, 0);
    check("rst_pfDisp", bus.pfDisp, 0);
    check("rst_cacheData", bus.cacheData, 0);

    // Preload every AC and every main-memory address the random phase may read.
    for (int i = 0; i < 16; i++) begin
      run_op(0, 1, 0, 1, {19'($urandom), 4'(i)}, {4'($urandom), $urandom}, lat);
      check("init_ac_lat", lat, 1);
    end
    for (int i = 0; i < 8; i++) begin
      init_val[i] = {4'($urandom), $urandom};
      run_op(0, 1, 0, 0, ADDR_W'(pool[i]), init_val[i], lat);
      check("init_mem_lat", lat, MEM_LAT + 1);
    end
    run_op(0, 1, 0, 0, 900, WORD_900, lat);
    run_op(0, 1, 0, 0, 960, WORD_960, lat);

    // Main-memory write then read.
    run_op(0, 1, 0, 0, 100, 36'o123456701234, lat);
    check("wr100_lat", lat, 3);
    run_op(1, 0, 0, 0, 100, '0, lat);
    check("rd100_lat", lat, 3);
    check("rd100_data", bus.cacheData, 36'o123456701234);
    check("rd100_pf", bus.pfDisp, 0);

    // AC path: vma 0o25 selects AC 5 and leaves main word 5 alone.
    run_op(0, 1, 0, 1, 23'o25, 7, lat);
    check("wr_ac5_lat", lat, 1);
    run_op(1, 0, 0, 1, 5, '0, lat);
    check("rd_ac5_lat", lat, 1);
    check("rd_ac5_data", bus.cacheData, 7);
    run_op(1, 0, 0, 0, 5, '0, lat);
    check("rd_mem5_data", bus.cacheData, init_val[1]);

    // Nonexistent memory.
    run_op(1, 0, 0, 0, ADDR_W'(DEPTH + 3), '0, lat);
    check("nxm_lat", lat, 1);
    check("nxm_pf", bus.pfDisp, 11'o1000);
    check("nxm_data_held", bus.cacheData, init_val[1]);
    @(negedge clk);
    check("nxm_pf_held", bus.pfDisp, 11'o1000);
    run_op(1, 0, 0, 0, 100, '0, lat);
    check("nxm_pf_cleared", bus.pfDisp, 0);

    // Read-pause-write on 200; the write's vma of 300 must be ignored.
    run_op(1, 0, 1, 0, 200, '0, lat);
    check("rpw_rd_lat", lat, 3);
    check("rpw_busy_ack", bus.busy, 1);
    @(negedge clk);
    check("rpw_busy_pause", bus.busy, 1);
    drive(1, 0, 0, 0, 200, '0);
    count_acks(4, acks);
    idle_inputs();
    check("pause_rd_ignored", acks, 0);
    run_op(0, 1, 0, 0, 300, 42, lat);
    check("rpw_wr_lat", lat, 3);
    run_op(1, 0, 0, 0, 200, '0, lat);
    check("rpw_200", bus.cacheData, 42);
    run_op(1, 0, 0, 0, 300, '0, lat);
    check("rpw_300", bus.cacheData, init_val[4]);

    // Held read is re-accepted at the edge ending each ack cycle.
    drive(1, 0, 0, 0, 100, '0);
    count_acks(1, acks);
    gap = 0;
    for (int i = 0; i < 20 && !bus.memAck; i++) @(negedge clk);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.memAck) begin
        gap = i;
        break;
      end
    end
    idle_inputs();
    check("b2b_gap", gap, MEM_LAT + 1);
    repeat (6) @(negedge clk);

    // Malformed requests.
    drive(1, 1, 0, 0, 100, '0);
    count_acks(5, acks);
    check("rd_wr_ignored", acks, 0);
    drive(0, 0, 0, 0, 100, '0);
    count_acks(3, acks);
    idle_inputs();
    check("none_ignored", acks, 0);

    // Randomised traffic, scored by the model every cycle.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      r = $urandom_range(0, 9);
      bus.req       = ($urandom_range(0, 9) < 7);
      bus.read      = (r < 4) || (r == 8);
      bus.write     = ((r >= 4) && (r < 8)) || (r == 8);
      bus.PSE       = ($urandom_range(0, 2) == 0);
      bus.vmaACRef  = ($urandom_range(0, 3) == 0);
      bus.writeData = {4'($urandom), $urandom};
      if (bus.vmaACRef)                  bus.vma = ADDR_W'($urandom);
      else if ($urandom_range(0, 4) == 0) bus.vma = ADDR_W'(DEPTH + $urandom_range(0, 8));
      else                               bus.vma = ADDR_W'(pool[$urandom_range(0, 7)]);
    end
    idle_inputs();
    @(posedge clk); #3 reset = 1'b1;
    #10 reset = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-ACCESS abandons the write to 900.
    drive(0, 1, 0, 0, 900, 36'h0_1111_2222);
    wait_accept(got);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    check("rstA_busy", bus.busy, 0);
    check("rstA_memAck", bus.memAck, 0);
    check("rstA_pfDisp", bus.pfDisp, 0);
    check("rstA_cacheData", bus.cacheData, 0);
    @(negedge clk); #1 reset = 1'b0;
    run_op(1, 0, 0, 0, 900, '0, lat);
    check("rstA_rd_lat", lat, 3);
    check("rstA_900", bus.cacheData, WORD_900);

    // Reset while paused.
    run_op(1, 0, 1, 0, 960, '0, lat);
    check("rstP_rd", bus.cacheData, WORD_960);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    check("rstP_busy", bus.busy, 0);
    check("rstP_cacheData", bus.cacheData, 0);
    @(negedge clk); #1 reset = 1'b0;
    run_op(1, 0, 0, 0, 960, '0, lat);
    check("rstP_rd_lat", lat, 3);
    check("rstP_960", bus.cacheData, WORD_960);
    @(negedge clk);
    check("rstP_idle", bus.busy, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule
